ex_forward_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage pipeline. It tracks destination-register state for the instructions in EX, MEM and WB. From that state it drives the 2-bit select inputs of the two EX-stage N-bit 4x1 operand muxes (ALU operand A and operand B). It also asserts the load-use stall toward IF/ID and inserts bubbles into the EX-side tracking on stall or branch flush.

---
 rtl/ex_forward_ctrl_pkg.sv | 8 +
 rtl/ex_forward_ctrl_if.sv | 28 ++
 rtl/ex_forward_ctrl_fwd_operand_sel.sv | 25 ++
 rtl/ex_forward_ctrl.sv | 74 +++++++
 tb/tb_ex_forward_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_forward_ctrl_pkg.sv
// riscv_pkg: shared operand-select encodings and register index width for the EX forwarding logic
package riscv_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_ALT   = 2'b11;
endpackage

// File: rtl/ex_forward_ctrl_if.sv
// ex_forward_ctrl_if: ID-stage decode info and flush in, stall and EX operand selects out
interface ex_forward_ctrl_if import riscv_pkg::*; #(parameter int REG_W = riscv_pkg::REG_W);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_a_pc;
  logic             id_b_imm;
  logic             ex_flush;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             ex_valid;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           id_a_pc, id_b_imm, ex_flush,
    input  stall, fwd_a_sel, fwd_b_sel, ex_valid
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
           id_a_pc, id_b_imm, ex_flush,
    output stall, fwd_a_sel, fwd_b_sel, ex_valid
  );
endinterface

// File: rtl/ex_forward_ctrl_fwd_operand_sel.sv
// fwd_operand_sel: 2-bit operand mux select for one EX source; forwarding paths only with FWD_PATH_EN
module fwd_operand_sel import riscv_pkg::*; #(parameter int REG_W = riscv_pkg::REG_W) (
  input  logic             ex_valid,
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  logic             alt,
  input  logic             exm_valid,
  input  logic             exm_we,
  input  logic [REG_W-1:0] exm_rd,
  input  logic             mwb_valid,
  input  logic             mwb_we,
  input  logic [REG_W-1:0] mwb_rd,
  output logic [1:0]       sel
);
`ifdef FWD_PATH_EN
  logic hit_exm, hit_mwb;
  assign hit_exm = exm_valid & exm_we & (|exm_rd) & (exm_rd == rs) & use_rs;
  assign hit_mwb = mwb_valid & mwb_we & (|mwb_rd) & (mwb_rd == rs) & use_rs;
  always_comb sel = !ex_valid ? FWD_RF : alt ? FWD_ALT : hit_exm ? FWD_EXMEM : hit_mwb ? FWD_MEMWB : FWD_RF;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs, use_rs, exm_valid, exm_we, exm_rd, mwb_valid, mwb_we, mwb_rd};
  always_comb sel = !ex_valid ? FWD_RF : alt ? FWD_ALT : FWD_RF;
`endif
endmodule

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX/MEM/WB destination tracking, operand forwarding selects and load-use stall.
// FWD_PATH_EN enables forwarding; without it every RAW hazard on EX/MEM stalls instead.
module ex_forward_ctrl import riscv_pkg::*; #(parameter int REG_W = riscv_pkg::REG_W) (
  input logic clk,
  input logic rst,
  ex_forward_ctrl_if.slave bus
);
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             a_pc;
    logic             b_imm;
  } idex_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } exm_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } mwb_t;
  idex_t idex_q, idex_d;
  exm_t  exm_q, exm_d;
  mwb_t  mwb_q, mwb_d;
  logic  stall, hit_idex, hit_exm, unused_q;
  assign hit_idex = (|idex_q.rd) & ((bus.id_use_rs1 & (bus.id_rs1 == idex_q.rd)) | (bus.id_use_rs2 & (bus.id_rs2 == idex_q.rd)));
  assign hit_exm  = (|exm_q.rd)  & ((bus.id_use_rs1 & (bus.id_rs1 == exm_q.rd))  | (bus.id_use_rs2 & (bus.id_rs2 == exm_q.rd)));
`ifdef FWD_PATH_EN
  assign stall = bus.id_valid & ~bus.ex_flush & idex_q.valid & idex_q.mem_read & hit_idex;
`else
  assign stall = bus.id_valid & ~bus.ex_flush &
                 ((idex_q.valid & idex_q.reg_write & hit_idex) | (exm_q.valid & exm_q.reg_write & hit_exm));
`endif
  assign unused_q = exm_q.mem_read;
  always_comb begin
    idex_d = '{valid: bus.id_valid & ~stall & ~bus.ex_flush, rs1: bus.id_rs1, rs2: bus.id_rs2,
               use_rs1: bus.id_use_rs1, use_rs2: bus.id_use_rs2, rd: bus.id_rd,
               reg_write: bus.id_reg_write, mem_read: bus.id_mem_read, a_pc: bus.id_a_pc, b_imm: bus.id_b_imm};
    exm_d  = '{valid: idex_q.valid & ~bus.ex_flush, rd: idex_q.rd, reg_write: idex_q.reg_write, mem_read: idex_q.mem_read};
    mwb_d  = '{valid: exm_q.valid, rd: exm_q.rd, reg_write: exm_q.reg_write};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
      exm_q  <= '0;
      mwb_q  <= '0;
    end else begin
      idex_q <= idex_d;
      exm_q  <= exm_d;
      mwb_q  <= mwb_d;
    end
  end
  fwd_operand_sel #(.REG_W(REG_W)) u_sel_a (
    .ex_valid(idex_q.valid), .rs(idex_q.rs1), .use_rs(idex_q.use_rs1), .alt(idex_q.a_pc),
    .exm_valid(exm_q.valid), .exm_we(exm_q.reg_write), .exm_rd(exm_q.rd),
    .mwb_valid(mwb_q.valid), .mwb_we(mwb_q.reg_write), .mwb_rd(mwb_q.rd), .sel(bus.fwd_a_sel)
  );
  fwd_operand_sel #(.REG_W(REG_W)) u_sel_b (
    .ex_valid(idex_q.valid), .rs(idex_q.rs2), .use_rs(idex_q.use_rs2), .alt(idex_q.b_imm),
    .exm_valid(exm_q.valid), .exm_we(exm_q.reg_write), .exm_rd(exm_q.rd),
    .mwb_valid(mwb_q.valid), .mwb_we(mwb_q.reg_write), .mwb_rd(mwb_q.rd), .sel(bus.fwd_b_sel)
  );
  assign bus.stall    = stall;
  assign bus.ex_valid = idex_q.valid;
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: directed hazard scenarios plus random traffic against an instruction-level pipeline model
module tb_ex_forward_ctrl;
  import riscv_pkg::*;
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit u1, u2, we, ld, apc, bimm;
  } ins_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  ex_forward_ctrl_if #(.REG_W(5)) bus();
  ex_forward_ctrl #(.REG_W(5)) dut(.clk(clk), .rst(rst), .bus(bus));
  ins_t pipe[3];
  ins_t id;
  bit   flush;
  int   checks = 0, errors = 0, s;
  function automatic ins_t mk(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit ld, bit apc, bit bimm);
    ins_t r;
    r.v = v; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.we = we; r.ld = ld; r.apc = apc; r.bimm = bimm;
    return r;
  endfunction
  function automatic ins_t nop();                       return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic ins_t alu(int rd, int rs1, int rs2); return mk(1, rd, rs1, rs2, 1, 1, 1, 0, 0, 0); endfunction
  function automatic ins_t lw(int rd, int rs1);          return mk(1, rd, rs1, 0, 1, 0, 1, 1, 0, 1); endfunction
  function automatic ins_t auipc(int rd);                return mk(1, rd, 0, 0, 0, 0, 1, 0, 1, 1); endfunction
  // The EX instruction's operand comes from the youngest older writer still in flight.
  function automatic int want_sel(bit alt, int rs, bit u);
    if (!pipe[0].v) return 0;
    if (alt) return 3;
`ifdef FWD_PATH_EN
    for (int k = 1; k < 3; k++)
      if (u && pipe[k].v && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == rs) return k;
`endif
    return 0;
  endfunction
  function automatic bit reads(int rd);
    return rd != 0 && ((id.u1 && id.rs1 == rd) || (id.u2 && id.rs2 == rd));
  endfunction
  function automatic bit want_stall();
    if (!id.v || flush) return 0;
`ifdef FWD_PATH_EN
    return pipe[0].v && pipe[0].ld && reads(pipe[0].rd);
`else
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].we && reads(pipe[k].rd)) return 1;
    return 0;
`endif
  endfunction
  task automatic apply();
    bus.id_valid = id.v;  bus.id_rs1 = 5'(id.rs1); bus.id_rs2 = 5'(id.rs2); bus.id_rd = 5'(id.rd);
    bus.id_use_rs1 = id.u1; bus.id_use_rs2 = id.u2; bus.id_reg_write = id.we; bus.id_mem_read = id.ld;
    bus.id_a_pc = id.apc; bus.id_b_imm = id.bimm; bus.ex_flush = flush;
  endtask
  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic check(string tag);
    cmp({tag, " stall"}, bus.stall, want_stall());
    cmp({tag, " ex_valid"}, bus.ex_valid, pipe[0].v);
    cmp({tag, " fwd_a"}, bus.fwd_a_sel, want_sel(pipe[0].apc, pipe[0].rs1, pipe[0].u1));
    cmp({tag, " fwd_b"}, bus.fwd_b_sel, want_sel(pipe[0].bimm, pipe[0].rs2, pipe[0].u2));
  endtask
  task automatic clear();
    for (int k = 0; k < 3; k++) pipe[k] = nop();
  endtask
  task automatic tick();
    bit st;
    st = want_stall();
    @(posedge clk);
    if (rst) clear();
    else begin
      pipe[2] = pipe[1];
      pipe[1] = flush ? nop() : pipe[0];
      pipe[0] = (flush || st) ? nop() : id;
    end
    #1;
  endtask
  task automatic step(string tag);
    apply(); #2; check(tag);
  endtask
  task automatic run(ins_t i, string tag, output int stalls);
    bit st;
    id = i; stalls = 0;
    for (int n = 0; n < 4; n++) begin
      step(tag);
      if (bus.stall === 1'b1) stalls++;
      st = want_stall();
      tick();
      if (!st) break;
    end
  endtask
  task automatic peek(string tag);
    id = nop(); step(tag);
  endtask
  task automatic drain();
    repeat (3) run(nop(), "drain", s);
  endtask
  initial begin
    id = nop(); flush = 0; clear(); apply();
    #1 rst = 1;
    #2 check("reset");
    cmp("reset stall", bus.stall, 0);
    cmp("reset ex_valid", bus.ex_valid, 0);
    @(posedge clk); #1 rst = 0;
    // asynchronous reset while a load-use stall is pending
    run(lw(8, 1), "rst_lw", s);
    id = alu(9, 8, 2); step("rst_use");
    cmp("rst pre stall", bus.stall, 1);
    rst = 1; clear(); #1;
    cmp("rst async stall", bus.stall, 0);
    cmp("rst async ex_valid", bus.ex_valid, 0);
    cmp("rst async fwd_a", bus.fwd_a_sel, 0);
    cmp("rst async fwd_b", bus.fwd_b_sel, 0);
    tick(); rst = 0;
    step("rst_release");
    tick();
    peek("no_bubble");
    cmp("no bubble ex_valid", bus.ex_valid, 1);
    tick();
    // back-to-back ALU dependency
    drain();
    run(alu(5, 1, 2), "w5", s);
    run(alu(6, 5, 1), "rd5", s);
    peek("rd5_ex");
`ifdef FWD_PATH_EN
    cmp("b2b stalls", s, 0);
    cmp("b2b fwd_a", bus.fwd_a_sel, 1);
`else
    cmp("b2b stalls", s, 2);
    cmp("b2b fwd_a", bus.fwd_a_sel, 0);
`endif
    tick();
    // one instruction gap, then priority of the younger writer
    drain();
    run(alu(5, 1, 2), "gap_w", s);
    run(nop(), "gap_nop", s);
    run(alu(7, 1, 5), "gap_rd", s);
    peek("gap_ex");
`ifdef FWD_PATH_EN
    cmp("gap stalls", s, 0);
    cmp("gap fwd_b", bus.fwd_b_sel, 2);
`else
    cmp("gap stalls", s, 1);
    cmp("gap fwd_b", bus.fwd_b_sel, 0);
`endif
    tick();
    drain();
    run(alu(5, 1, 2), "pri_w0", s);
    run(alu(5, 3, 4), "pri_w1", s);
    run(alu(7, 1, 5), "pri_rd", s);
    peek("pri_ex");
`ifdef FWD_PATH_EN
    cmp("priority fwd_b", bus.fwd_b_sel, 1);
`else
    cmp("priority fwd_b", bus.fwd_b_sel, 0);
`endif
    tick();
    // load-use with rs1==rs2
    drain();
    run(lw(8, 1), "lu_lw", s);
    run(alu(9, 8, 8), "lu_use", s);
    peek("lu_ex");
`ifdef FWD_PATH_EN
    cmp("load-use stalls", s, 1);
    cmp("load-use fwd_a", bus.fwd_a_sel, 2);
    cmp("load-use fwd_b", bus.fwd_b_sel, 2);
`else
    cmp("load-use stalls", s, 2);
    cmp("load-use fwd_a", bus.fwd_a_sel, 0);
`endif
    tick();
    // x0 is never a hazard
    drain();
    run(alu(0, 1, 2), "x0_w", s);
    run(alu(1, 0, 0), "x0_rd", s);
    peek("x0_ex");
    cmp("x0 stalls", s, 0);
    cmp("x0 fwd_a", bus.fwd_a_sel, 0);
    cmp("x0 fwd_b", bus.fwd_b_sel, 0);
    tick();
    // alternate operands
    drain();
    run(auipc(3), "alt", s);
    peek("alt_ex");
    cmp("alt fwd_a", bus.fwd_a_sel, 3);
    cmp("alt fwd_b", bus.fwd_b_sel, 3);
    tick();
    // flush during a load-use stall
    drain();
    run(lw(8, 1), "fl_lw", s);
    id = alu(9, 8, 8); step("fl_use");
    cmp("flush pre stall", bus.stall, 1);
    flush = 1; apply(); #1;
    cmp("flush stall", bus.stall, 0);
    tick(); flush = 0;
    id = alu(10, 8, 8); step("fl_after");
    cmp("flush ex_valid", bus.ex_valid, 0);
    cmp("flush no stall", bus.stall, 0);
    tick();
    peek("fl_ex");
    cmp("flush exmem killed", bus.fwd_a_sel, 0);
    tick();
    // random traffic with small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (!want_stall())
        id = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 4) == 0));
      flush = $urandom_range(0, 9) == 0;
      step("rand");
      tick();
    end
    flush = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
